// File: rtl/pwm_setpoint_ramp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pwm_setpoint_ramp_pkg
// Purpose  : Shared constants and FSM encoding for the PWM setpoint slew
//            limiter. FRAC_BITS is the fraction size shared with the
//            fractional PWM stage.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package pwm_setpoint_ramp_pkg;

    // Fractional duty bits; must match the downstream PWM fraction size.
    localparam int FRAC_BITS  = 3;

    // Default integer duty width (matches PWM No/N/mf width).
    localparam int DUTY_WIDTH = 17;

    // Ramp controller states, 2-bit encoding.
    typedef enum logic [1:0] {
        RAMP_IDLE = 2'd0,
        RAMP_ARM  = 2'd1,
        RAMP_RUN  = 2'd2
    } ramp_state_t;

endpackage : pwm_setpoint_ramp_pkg
`default_nettype wire

// File: rtl/pwm_setpoint_ramp_step.sv
`default_nettype none
// ============================================================================
// Module   : pwm_setpoint_ramp_step
// Purpose  : Combinational saturating step toward a target duty. Produces the
//            setpoint after one period's move and flags when that move lands
//            exactly on the (ceiling-limited) target.
// Ports    : cur      in  WIDTH+FRAC  present setpoint, Q.FRAC unsigned
//            tgt      in  WIDTH+FRAC  registered target, Q.FRAC unsigned
//            step     in  WIDTH+FRAC  max move per period; 0 = full jump
//            ceil     in  WIDTH+FRAC  duty ceiling {No, FRAC'b0}
//            next_cur out WIDTH+FRAC  setpoint after this period's move
//            reached  out 1           next_cur equals min(tgt, ceil)
// Revision : 1.0 - initial release
// ============================================================================
module pwm_setpoint_ramp_step #(
    parameter int WIDTH = 17,
    parameter int FRAC  = 3
) (
    input  logic [WIDTH+FRAC-1:0] cur,
    input  logic [WIDTH+FRAC-1:0] tgt,
    input  logic [WIDTH+FRAC-1:0] step,
    input  logic [WIDTH+FRAC-1:0] ceil,
    output logic [WIDTH+FRAC-1:0] next_cur,
    output logic                  reached
);

    localparam int DW = WIDTH + FRAC;

    logic [DW-1:0]        w_eff_tgt;
    logic signed [DW:0]   w_diff;
    logic [DW:0]          w_abs;
    logic [DW:0]          w_move;
    logic signed [DW:0]   w_sum;

    always_comb begin
        // The ceiling may have dropped below the registered target since the
        // target was accepted; never aim above the present ceiling.
        w_eff_tgt = (tgt > ceil) ? ceil : tgt;

        w_diff = $signed({1'b0, w_eff_tgt}) - $signed({1'b0, cur});
        w_abs  = w_diff[DW] ? $unsigned(-w_diff) : $unsigned(w_diff);

        // step == 0 means "jump"; a step larger than the gap must not overshoot.
        if ((step == '0) || ({1'b0, step} > w_abs)) begin
            w_move = w_abs;
        end else begin
            w_move = {1'b0, step};
        end

        if (w_diff[DW]) begin
            w_sum = $signed({1'b0, cur}) - $signed(w_move);
        end else begin
            w_sum = $signed({1'b0, cur}) + $signed(w_move);
        end

        // Saturate at both rails; a setpoint above the ceiling is pulled
        // straight down to it regardless of step.
        if (cur > ceil) begin
            next_cur = ceil;
        end else if (w_sum < 0) begin
            next_cur = '0;
        end else if (w_sum > $signed({1'b0, ceil})) begin
            next_cur = ceil;
        end else begin
            next_cur = w_sum[DW-1:0];
        end

        reached = (next_cur == w_eff_tgt);
    end

endmodule : pwm_setpoint_ramp_step
`default_nettype wire

// File: rtl/pwm_setpoint_ramp.sv
`default_nettype none
// ============================================================================
// Module   : pwm_setpoint_ramp
// Purpose  : Slew-rate limiter ahead of the fractional PWM stage. Accepts a
//            target duty (Q(WIDTH).FRAC) and steps the live setpoint toward it
//            once per PWM period, so the PWM never sees a mid-period change.
// Ports    : clk          in  1           system clock
//            rst          in  1           asynchronous active-high reset
//            period_tick  in  1           PWM period boundary pulse
//            no_limit     in  WIDTH       period divider No (duty ceiling)
//            tgt_valid    in  1           target offer
//            tgt_ready    out 1           target accept (always 1)
//            tgt_duty     in  WIDTH+FRAC  target duty, Q.FRAC unsigned
//            step         in  WIDTH+FRAC  max change per period; 0 = jump
//            n_out        out WIDTH       integer setpoint -> PWM N
//            mf_out       out WIDTH       fractional setpoint -> PWM mf
//            busy         out 1           ramp in progress
//            done         out 1           one-cycle pulse when target reached
//            clamped      out 1           last accepted target hit the ceiling
// Revision : 1.0 - initial release
// ============================================================================
module pwm_setpoint_ramp
    import pwm_setpoint_ramp_pkg::*;
#(
    parameter int WIDTH = DUTY_WIDTH,
    parameter int FRAC  = FRAC_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  period_tick,
    input  logic [WIDTH-1:0]      no_limit,
    input  logic                  tgt_valid,
    output logic                  tgt_ready,
    input  logic [WIDTH+FRAC-1:0] tgt_duty,
    input  logic [WIDTH+FRAC-1:0] step,
    output logic [WIDTH-1:0]      n_out,
    output logic [WIDTH-1:0]      mf_out,
    output logic                  busy,
    output logic                  done,
    output logic                  clamped
);

    localparam int DW = WIDTH + FRAC;

    ramp_state_t   r_state;
    ramp_state_t   w_state_nxt;

    logic [DW-1:0] r_cur;
    logic [DW-1:0] r_tgt;
    logic          r_done;
    logic          r_clamped;

    logic [DW-1:0] w_cur_nxt;
    logic [DW-1:0] w_tgt_nxt;
    logic          w_done_nxt;
    logic          w_clamped_nxt;

    logic [DW-1:0] w_ceil;
    logic [DW-1:0] w_acc_tgt;
    logic          w_acc_clamp;
    logic [DW-1:0] w_old_tgt_lim;
    logic [DW-1:0] w_step_cur;
    logic          w_step_reached;
    logic          w_land;

    assign w_ceil        = {no_limit, {FRAC{1'b0}}};
    assign w_acc_clamp   = (tgt_duty > w_ceil);
    assign w_acc_tgt     = w_acc_clamp ? w_ceil : tgt_duty;
    assign w_old_tgt_lim = (r_tgt > w_ceil) ? w_ceil : r_tgt;

    // The step always works from the target registered before this cycle; a
    // target accepted on a tick only takes effect from the next period.
    pwm_setpoint_ramp_step #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) u_step (
        .cur      (r_cur),
        .tgt      (r_tgt),
        .step     (step),
        .ceil     (w_ceil),
        .next_cur (w_step_cur),
        .reached  (w_step_reached)
    );

    // When a new target arrives with the tick, completion is judged against
    // the new target, not the one the step was computed for.
    assign w_land = tgt_valid ? (w_step_cur == w_acc_tgt) : w_step_reached;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RAMP_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cur_nxt     = r_cur;
        w_tgt_nxt     = r_tgt;
        w_done_nxt    = 1'b0;
        w_clamped_nxt = r_clamped;

        if (tgt_valid) begin
            w_tgt_nxt     = w_acc_tgt;
            w_clamped_nxt = w_acc_clamp;
        end

        case (r_state)
            RAMP_IDLE: begin
                // Ticks are ignored here; only a target that differs from
                // the live setpoint starts a ramp.
                if (tgt_valid && (w_acc_tgt != r_cur)) begin
                    w_state_nxt = RAMP_ARM;
                end
            end

            RAMP_ARM, RAMP_RUN: begin
                if (period_tick) begin
                    w_cur_nxt = w_step_cur;
                    if (!tgt_valid) begin
                        w_tgt_nxt = w_old_tgt_lim;
                    end
                    if (w_land) begin
                        w_state_nxt = RAMP_IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = RAMP_RUN;
                    end
                end
            end

            default: begin
                w_state_nxt = RAMP_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cur     <= '0;
            r_tgt     <= '0;
            r_done    <= 1'b0;
            r_clamped <= 1'b0;
        end else begin
            r_cur     <= w_cur_nxt;
            r_tgt     <= w_tgt_nxt;
            r_done    <= w_done_nxt;
            r_clamped <= w_clamped_nxt;
        end
    end

    assign tgt_ready = 1'b1;
    assign n_out     = r_cur[DW-1:FRAC];
    assign mf_out    = {{(WIDTH-FRAC){1'b0}}, r_cur[FRAC-1:0]};
    assign busy      = (r_state != RAMP_IDLE);
    assign done      = r_done;
    assign clamped   = r_clamped;

endmodule : pwm_setpoint_ramp
`default_nettype wire

// File: tb/tb_pwm_setpoint_ramp.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_setpoint_ramp
// Purpose  : Directed and randomized bench for pwm_setpoint_ramp with a
//            behavioural duty model in plain integer arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_setpoint_ramp;

    localparam int WIDTH = 17;
    localparam int FRAC  = 3;

    logic                  clk;
    logic                  rst;
    logic                  period_tick;
    logic [WIDTH-1:0]      no_limit;
    logic                  tgt_valid;
    logic                  tgt_ready;
    logic [WIDTH+FRAC-1:0] tgt_duty;
    logic [WIDTH+FRAC-1:0] step;
    logic [WIDTH-1:0]      n_out;
    logic [WIDTH-1:0]      mf_out;
    logic                  busy;
    logic                  done;
    logic                  clamped;

    int checks = 0;
    int errors = 0;

    // Model state: setpoint and target in eighths, plus a "ramp pending" flag.
    int m_cur;
    int m_tgt;
    bit m_act;
    bit m_done;
    bit m_clamped;

    int exp_n [6] = '{2, 4, 6, 8, 10, 10};
    int exp_mf[6] = '{0, 0, 0, 0, 0, 3};
    int exp_dn[4] = '{6, 5, 4, 3};

    pwm_setpoint_ramp #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .period_tick (period_tick),
        .no_limit    (no_limit),
        .tgt_valid   (tgt_valid),
        .tgt_ready   (tgt_ready),
        .tgt_duty    (tgt_duty),
        .step        (step),
        .n_out       (n_out),
        .mf_out      (mf_out),
        .busy        (busy),
        .done        (done),
        .clamped     (clamped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One period's move toward a target already limited to the ceiling.
    function automatic int move_to(int cur, int tgt, int stp, int ceil_v);
        if (cur > ceil_v) return ceil_v;
        if (stp == 0)     return tgt;
        if (cur < tgt)    return (cur + stp > tgt) ? tgt : cur + stp;
        return (cur - stp < tgt) ? tgt : cur - stp;
    endfunction

    task automatic model_reset();
        m_cur = 0; m_tgt = 0; m_act = 0; m_done = 0; m_clamped = 0;
    endtask

    task automatic check_outputs();
        check("n_out",     n_out,     m_cur / 8);
        check("mf_out",    mf_out,    m_cur % 8);
        check("busy",      busy,      m_act);
        check("done",      done,      m_done);
        check("clamped",   clamped,   m_clamped);
        check("tgt_ready", tgt_ready, 1);
    endtask

    // Advance one clock: predict from the inputs in force, then compare.
    task automatic clk_step();
        int ceil_v, newt, lim, nc, nt;
        bit na, nd, ncl;
        ceil_v = int'(no_limit) * 8;
        newt   = (int'(tgt_duty) > ceil_v) ? ceil_v : int'(tgt_duty);
        nc = m_cur; nt = m_tgt; na = m_act; nd = 0; ncl = m_clamped;
        if (tgt_valid) ncl = (int'(tgt_duty) > ceil_v);
        if (!m_act) begin
            if (tgt_valid) begin
                nt = newt;
                if (newt != m_cur) na = 1;
            end
        end else if (period_tick) begin
            lim = (m_tgt > ceil_v) ? ceil_v : m_tgt;
            nc  = move_to(m_cur, lim, int'(step), ceil_v);
            nt  = tgt_valid ? newt : lim;
            if (nc == nt) begin
                na = 0;
                nd = 1;
            end
        end else if (tgt_valid) begin
            nt = newt;
        end
        @(posedge clk);
        #1;
        if (rst) begin
            model_reset();
        end else begin
            m_cur = nc; m_tgt = nt; m_act = na; m_done = nd; m_clamped = ncl;
        end
        check_outputs();
    endtask

    task automatic idle(input int n);
        repeat (n) clk_step();
    endtask

    task automatic tick();
        period_tick = 1'b1;
        clk_step();
        period_tick = 1'b0;
    endtask

    task automatic accept(input int v);
        tgt_valid = 1'b1;
        tgt_duty  = v[WIDTH+FRAC-1:0];
        clk_step();
        tgt_valid = 1'b0;
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        clk_step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; period_tick = 1'b0; tgt_valid = 1'b0;
        tgt_duty = '0; step = '0; no_limit = 17'd100;
        model_reset();
        idle(2);
        check("reset_n", n_out, 0);
        check("reset_busy", busy, 0);
        rst = 1'b0;
        idle(1);

        // Reset in the middle of a ramp at 40.5
        accept(320);
        tick();
        check("t1_jump_n", n_out, 40);
        step = 4;
        accept(800);
        idle(1);
        tick();
        check("t1_mid_n", n_out, 40);
        check("t1_mid_mf", mf_out, 4);
        check("t1_mid_busy", busy, 1);
        rst = 1'b1;
        #1;
        model_reset();
        check("t1_async_n", n_out, 0);
        check("t1_async_mf", mf_out, 0);
        check("t1_async_busy", busy, 0);
        clk_step();
        rst = 1'b0;
        tick();
        check("t1_after_tick_n", n_out, 0);

        // Ramp 0 -> 10.375 in steps of 2.0
        step = 16;
        accept(83);
        idle(2);
        check("t2_latency_n", n_out, 0);
        check("t2_latency_busy", busy, 1);
        for (int i = 0; i < 6; i++) begin
            idle(3);
            tick();
            check("t2_n", n_out, exp_n[i]);
            check("t2_mf", mf_out, exp_mf[i]);
            check("t2_done", done, (i == 5) ? 1 : 0);
        end
        idle(1);
        check("t2_done_one_cycle", done, 0);

        // Jump to 50.0 with step 0
        reset_pulse();
        step = 0;
        accept(400);
        tick();
        check("t3_n", n_out, 50);
        check("t3_mf", mf_out, 0);
        check("t3_done", done, 1);
        check("t3_busy", busy, 0);

        // Clamp to ceiling 20, then clear with 5.0
        no_limit = 17'd20;
        accept(200);
        check("t4_clamped", clamped, 1);
        tick();
        check("t4_n", n_out, 20);
        accept(40);
        check("t4_unclamped", clamped, 0);
        tick();
        check("t4_n5", n_out, 5);

        // Reversal accepted on the same cycle as a tick
        no_limit = 17'd100;
        step = 8;
        accept(80);
        tick();
        check("t5_setup_n", n_out, 6);
        tgt_valid = 1'b1; tgt_duty = 24; period_tick = 1'b1;
        clk_step();
        tgt_valid = 1'b0; period_tick = 1'b0;
        check("t5_old_tgt_n", n_out, 7);
        check("t5_busy", busy, 1);
        for (int i = 0; i < 4; i++) begin
            idle(2);
            tick();
            check("t5_n", n_out, exp_dn[i]);
            check("t5_done", done, (i == 3) ? 1 : 0);
        end

        // Ceiling drop below an idle setpoint of 30.0
        step = 0;
        accept(240);
        tick();
        check("t6_setup_n", n_out, 30);
        step = 8;
        no_limit = 17'd12;
        accept(240);
        check("t6_clamped", clamped, 1);
        tick();
        check("t6_n", n_out, 12);
        check("t6_mf", mf_out, 0);
        check("t6_done", done, 1);
        idle(1);
        tick();
        check("t6_no_overshoot", n_out, 12);

        // Randomized traffic against the model
        no_limit = 17'd100;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 63) == 0) no_limit = 17'($urandom_range(5, 120));
            tgt_valid   = ($urandom_range(0, 7) == 0);
            tgt_duty    = 20'($urandom_range(0, 1100));
            step        = ($urandom_range(0, 3) == 0) ? 20'd0 : 20'($urandom_range(1, 40));
            period_tick = ($urandom_range(0, 4) == 0);
            clk_step();
        end
        tgt_valid = 1'b0;
        period_tick = 1'b0;
        idle(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_pwm_setpoint_ramp
`default_nettype wire
